prot_bridge_mc: RTL

//  Parametrised, multi-channel successor to the 8-bit RGA/RGB -> RGZ bridge.

---
 rtl/prot_bridge_mc.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/prot_bridge_mc.sv
// Multi-channel protection bridge: key-sequence write lock with idle timeout,
// per-channel result registers and an opcode-selected saturating ALU.
module prot_bridge_mc #(
    parameter  int W   = 8,
    parameter  int NCH = 4,
    parameter  int TMO = 16,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int TW  = $clog2(TMO)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           ENA,
    input  logic [2:0]     OPT,
    input  logic [CHW-1:0] CH,
    input  logic [1:0]     KEY,
    input  logic [W-1:0]   RGA,
    input  logic [W-1:0]   RGB,
    output logic [W-1:0]   RGZ,
    output logic           VLD,
    output logic           ERR,
    output logic           LOCKED
);

    typedef enum logic [1:0] {S_LOCKED, S_ARM, S_OPEN} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [W-1:0]  rgz_q, rgz_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;
    logic [W-1:0]  chreg_q [NCH];

    logic [W-1:0]  rd_val;
    logic          ch_ok;
    logic [W-1:0]  alu_r;
    logic [W:0]    sum;
    logic          wr_en;

    // Channel mux by compare so a non-power-of-2 NCH never indexes past the array.
    always_comb begin
        rd_val = '0;
        ch_ok  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (CH == CHW'(i)) begin
                rd_val = chreg_q[i];
                ch_ok  = 1'b1;
            end
        end
    end

    always_comb begin
        sum = {1'b0, RGA} + {1'b0, RGB};
        case (OPT)
            3'd0:    alu_r = RGA;
            3'd1:    alu_r = RGA & RGB;
            3'd2:    alu_r = RGA | RGB;
            3'd3:    alu_r = RGA ^ RGB;
            3'd4:    alu_r = sum[W] ? '1 : sum[W-1:0];
            3'd5:    alu_r = (RGA > RGB) ? (RGA - RGB) : '0;
            3'd6:    alu_r = ~RGA;
            default: alu_r = rd_val;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        rgz_d   = rgz_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        if (ENA) begin
            idle_d = '0;
            case (state_q)
                S_LOCKED: begin
                    if (KEY == 2'b01) begin
                        state_d = S_ARM;
                    end else if (KEY == 2'b00 && OPT == 3'd7 && ch_ok) begin
                        rgz_d = rd_val;
                        vld_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_ARM: begin
                    if (KEY == 2'b10) begin
                        state_d = S_OPEN;
                    end else begin
                        state_d = S_LOCKED;
                        err_d   = 1'b1;
                    end
                end
                S_OPEN: begin
                    case (KEY)
                        2'b00: begin
                            if (!ch_ok) begin
                                err_d = 1'b1;
                            end else begin
                                rgz_d = alu_r;
                                vld_d = 1'b1;
                                wr_en = (OPT != 3'd7);
                            end
                        end
                        2'b11:   state_d = S_LOCKED;
                        default: err_d = 1'b1;
                    endcase
                end
                default: state_d = S_LOCKED;
            endcase
        end else if (state_q != S_LOCKED) begin
            // Fires on the edge that completes the TMO-th consecutive idle cycle.
            if (idle_q == TW'(TMO - 1)) begin
                state_d = S_LOCKED;
                idle_d  = '0;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_LOCKED;
            idle_q  <= '0;
            rgz_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NCH; i++) chreg_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            rgz_q   <= rgz_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            for (int i = 0; i < NCH; i++) begin
                if (wr_en && CH == CHW'(i)) chreg_q[i] <= alu_r;
            end
        end
    end

    assign RGZ    = rgz_q;
    assign VLD    = vld_q;
    assign ERR    = err_q;
    assign LOCKED = (state_q == S_LOCKED);

endmodule
